decode_stage_pipelined: RTL
===========================

Name: decode_stage_pipelined

Overview:
Parametrised successor to the combinational ID stage. It owns the ID/EX pipeline register, so every decode output is registered.
- Adds a reset-clearable register file with write-to-read bypass.
- Adds load-use hazard detection with stall and bubble insertion.
- Adds flush on taken branch or jump.
- Adds immediate mode selection (sign-extend, zero-extend, or LUI shift).
- Sits between the IF/ID register and execute.

Parameters:
len, 32, datapath and instruction width (instruction field slicing requires 32)
NB, $clog2(len), register-index width
REG_COUNT, 32, number of architectural registers (≤ 2**NB)
HAZARD_EN, 1, 1 = load-use detection active; 0 = out_stall tied 0
BYPASS_EN, 1, 1 = same-cycle write data forwarded to reads

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 clears all state
in_valid  in  1  IF/ID holds a real instruction
in_pc_branch  in  len  PC+4 of the instruction
in_instruccion  in  len  instruction word
flush  in  1  kill the instruction currently in ID
RegWrite  in  1  writeback enable
write_register  in  NB  writeback index
write_data  in  len  writeback data
out_stall  out  1  hold PC and IF/ID this cycle (combinational)
out_valid  out  1  ID/EX entry valid
out_pc_branch  out  len  registered PC+4
out_pc_jump  out  len  registered jump target
out_reg1  out  len  registered rs data
out_reg2  out  len  registered rt data
out_imm  out  len  registered extended immediate
out_rs, out_rt, out_rd, out_shamt  out  NB each  registered fields
execute_bus  out  4  {RegDst, ALUOp[1:0], ALUSrc}
memory_bus  out  3  {MemRead, MemWrite, Branch}
writeBack_bus  out  2  {RegWrite, MemtoReg}

Behaviour:
Reset
- reset=0 asynchronously clears all ID/EX outputs and every register-file entry to 0.
- out_valid=0 during reset.

Latency
- Exactly 1 cycle from in_instruccion to the registered outputs.

Register file
- Written on the rising edge when RegWrite=1 and write_register≠0 and write_register<REG_COUNT.
- Writes to index 0 are ignored; index 0 always reads 0.
- Indices ≥ REG_COUNT read 0.

Bypass (BYPASS_EN=1)
- If RegWrite=1, write_register≠0 and write_register equals rs (or rt), the read value is write_data, not the stored value.

Hazard (HAZARD_EN=1)
- hz = out_valid & memory_bus[2] & (out_rt≠0) & (out_rt==rs | out_rt==rt).
- out_stall = hz & in_valid & ~flush.

Load priority on each clock edge, highest first:
- reset: clear.
- flush=1: bubble (out_valid=0, all three control buses 0, data fields don't-care but loaded 0).
- out_stall=1: bubble; IF/ID is held upstream, so the instruction re-decodes next cycle.
- in_valid=0: bubble.
- Otherwise: load the decoded instruction with out_valid=1.

Control decode (opcode = instr[31:26])
- R-type 0x00: execute_bus 4'b1100, memory_bus 0, writeBack_bus 2'b10.
- LW 0x23: 4'b0001, 3'b100, 2'b11.
- SW 0x2B: 4'b0001, 3'b010, 2'b00.
- BEQ 0x04: 4'b0010, 3'b001, 2'b00.
- ADDI 0x08, ANDI 0x0C, ORI 0x0D, XORI 0x0E, LUI 0x0F, SLTI 0x0A: 4'b0111, 0, 2'b10.
- J 0x02: all control buses 0.
- Unknown opcode: all control buses 0, out_valid still 1.

Immediate
- ANDI/ORI/XORI: zero-extend instr[15:0].
- LUI: {instr[15:0], 16'b0}.
- All others: sign-extend instr[15:0].

Jump target
- {in_pc_branch[31:28], instr[25:0], 2'b00}.

Simultaneous events
- flush with hazard: flush wins, out_stall=0.
- Writeback to a register being read during a stall: the bypass applies on the re-decode; the register file already holds the value.

Decomposition:
Shared package mips_pkg holds:
- opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_SLTI);
- bus widths EX_W=4, MEM_W=3, WB_W=2;
- bit indices MEM_READ_BIT=2, WB_REGWRITE_BIT=1.

Sub-module: hazard_unit (combinational load-use compare, produces out_stall). Register file and control table stay inline.

Test Plan:
1. Reset: hold reset=0 with random inputs -> every output 0, out_valid=0; release reset -> first valid instruction appears 1 cycle later.
2. Bypass: write r5=0xDEADBEEF (RegWrite=1) in the same cycle ID decodes ADD r3,r5,r0 -> next cycle out_reg1=0xDEADBEEF, out_reg2=0.
3. Load-use: LW r2,4(r1), then ADD r4,r2,r2 -> out_stall=1 for one cycle and a bubble is inserted (out_valid=0); the next cycle ADD loads with out_stall=0.
4. Flush: flush=1 with BEQ in ID that would also stall -> out_stall=0, out_valid=0, memory_bus=0.
5. Immediates: ORI 0xFFFF -> out_imm=0x0000FFFF; ADDI 0xFFFF -> 0xFFFFFFFF; LUI 0x1234 -> 0x12340000.
6. Jump and r0: J 0x0000010 with in_pc_branch=0xA0000004 -> out_pc_jump=0xA0000040; write r0=0x55 then read r0 -> 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, control-bus widths and bit positions.
// Latency: n/a (package).
// Backpressure: n/a (package).
package mips_pkg;

  // Primary opcodes, taken from instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Control bus widths: execute {RegDst, ALUOp[1:0], ALUSrc},
  // memory {MemRead, MemWrite, Branch}, writeback {RegWrite, MemtoReg}
  localparam int EX_W  = 4;
  localparam int MEM_W = 3;
  localparam int WB_W  = 2;

  localparam int MEM_READ_BIT    = 2;
  localparam int WB_REGWRITE_BIT = 1;

endpackage

// File: rtl/decode_stage_pipelined_hazard.sv
// Load-use hazard detect: stalls ID when EX holds a load whose rt feeds rs/rt in ID.
// Latency: purely combinational, 0 cycles.
// Backpressure: stall holds PC and IF/ID upstream; flush overrides and drops the stall.
module hazard_unit #(
  parameter int NB        = 5,
  parameter int HAZARD_EN = 1
) (
  input  logic          ex_valid,
  input  logic          ex_mem_read,
  input  logic [NB-1:0] ex_rt,
  input  logic [NB-1:0] id_rs,
  input  logic [NB-1:0] id_rt,
  input  logic          id_valid,
  input  logic          flush,
  output logic          stall
);

  logic hz;

  // Compare the load destination in EX against both source fields in ID
  always_comb begin
    hz    = ex_valid & ex_mem_read & (ex_rt != '0) &
            ((ex_rt == id_rs) | (ex_rt == id_rt));
    stall = (HAZARD_EN != 0) ? (hz & id_valid & ~flush) : 1'b0;
  end

endmodule

// File: rtl/decode_stage_pipelined.sv
// ID stage with register file, bypass, load-use stall, flush and the ID/EX register.
// Latency: 1 cycle from in_instruccion to every registered output.
// Backpressure: out_stall (combinational) holds IF/ID; a bubble is loaded meanwhile.
module decode_stage_pipelined
  import mips_pkg::*;
#(
  parameter int len       = 32,
  parameter int NB        = $clog2(len),
  parameter int REG_COUNT = 32,
  parameter int HAZARD_EN = 1,
  parameter int BYPASS_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [len-1:0]   in_pc_branch,
  input  logic [len-1:0]   in_instruccion,
  input  logic             flush,
  input  logic             RegWrite,
  input  logic [NB-1:0]    write_register,
  input  logic [len-1:0]   write_data,
  output logic             out_stall,
  output logic             out_valid,
  output logic [len-1:0]   out_pc_branch,
  output logic [len-1:0]   out_pc_jump,
  output logic [len-1:0]   out_reg1,
  output logic [len-1:0]   out_reg2,
  output logic [len-1:0]   out_imm,
  output logic [NB-1:0]    out_rs,
  output logic [NB-1:0]    out_rt,
  output logic [NB-1:0]    out_rd,
  output logic [NB-1:0]    out_shamt,
  output logic [EX_W-1:0]  execute_bus,
  output logic [MEM_W-1:0] memory_bus,
  output logic [WB_W-1:0]  writeBack_bus
);

  logic [len-1:0] rf [REG_COUNT];

  logic [5:0]      opcode;
  logic [NB-1:0]   rs, rt, rd, shamt;
  logic [15:0]     imm16;
  logic [len-1:0]  rs_dat, rt_dat, imm_ext, jump_tgt;
  logic [EX_W-1:0] ex_c;
  logic [MEM_W-1:0] mem_c;
  logic [WB_W-1:0] wb_c;
  logic            wr_en;

  function automatic logic in_range(input logic [NB-1:0] idx);
    return int'(idx) < REG_COUNT;
  endfunction

  assign opcode   = in_instruccion[31:26];
  assign rs       = NB'(in_instruccion[25:21]);
  assign rt       = NB'(in_instruccion[20:16]);
  assign rd       = NB'(in_instruccion[15:11]);
  assign shamt    = NB'(in_instruccion[10:6]);
  assign imm16    = in_instruccion[15:0];
  assign jump_tgt = {in_pc_branch[31:28], in_instruccion[25:0], 2'b00};
  assign wr_en    = RegWrite && (write_register != '0) && in_range(write_register);

  // Register file: async clear, r0 and out-of-range indices never written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[write_register] <= write_data;
    end
  end

  // Read ports: r0/out-of-range read 0, same-cycle writeback forwarded
  always_comb begin
    rs_dat = '0;
    rt_dat = '0;
    if (rs != '0 && in_range(rs)) begin
      if (BYPASS_EN != 0 && wr_en && write_register == rs) rs_dat = write_data;
      else                                               rs_dat = rf[rs];
    end
    if (rt != '0 && in_range(rt)) begin
      if (BYPASS_EN != 0 && wr_en && write_register == rt) rt_dat = write_data;
      else                                               rt_dat = rf[rt];
    end
  end

  // Control table and immediate selection by opcode
  always_comb begin
    ex_c    = '0;
    mem_c   = '0;
    wb_c    = '0;
    imm_ext = {{(len-16){imm16[15]}}, imm16};
    case (opcode)
      OP_RTYPE: begin ex_c = 4'b1100; wb_c = 2'b10; end
      OP_LW:    begin ex_c = 4'b0001; mem_c = 3'b100; wb_c = 2'b11; end
      OP_SW:    begin ex_c = 4'b0001; mem_c = 3'b010; end
      OP_BEQ:   begin ex_c = 4'b0010; mem_c = 3'b001; end
      OP_ADDI, OP_SLTI: begin ex_c = 4'b0111; wb_c = 2'b10; end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ex_c    = 4'b0111;
        wb_c    = 2'b10;
        imm_ext = {{(len-16){1'b0}}, imm16};
      end
      OP_LUI: begin
        ex_c    = 4'b0111;
        wb_c    = 2'b10;
        imm_ext = {imm16, {(len-16){1'b0}}};
      end
      default: ;
    endcase
  end

  hazard_unit #(
    .NB        (NB),
    .HAZARD_EN (HAZARD_EN)
  ) u_hazard (
    .ex_valid    (out_valid),
    .ex_mem_read (memory_bus[MEM_READ_BIT]),
    .ex_rt       (out_rt),
    .id_rs       (rs),
    .id_rt       (rt),
    .id_valid    (in_valid),
    .flush       (flush),
    .stall       (out_stall)
  );

  // ID/EX register: flush, stall and empty slot all load a zeroed bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid     <= 1'b0;
      out_pc_branch <= '0;
      out_pc_jump   <= '0;
      out_reg1      <= '0;
      out_reg2      <= '0;
      out_imm       <= '0;
      out_rs        <= '0;
      out_rt        <= '0;
      out_rd        <= '0;
      out_shamt     <= '0;
      execute_bus   <= '0;
      memory_bus    <= '0;
      writeBack_bus <= '0;
    end else if (flush || out_stall || !in_valid) begin
      out_valid     <= 1'b0;
      out_pc_branch <= '0;
      out_pc_jump   <= '0;
      out_reg1      <= '0;
      out_reg2      <= '0;
      out_imm       <= '0;
      out_rs        <= '0;
      out_rt        <= '0;
      out_rd        <= '0;
      out_shamt     <= '0;
      execute_bus   <= '0;
      memory_bus    <= '0;
      writeBack_bus <= '0;
    end else begin
      out_valid     <= 1'b1;
      out_pc_branch <= in_pc_branch;
      out_pc_jump   <= jump_tgt;
      out_reg1      <= rs_dat;
      out_reg2      <= rt_dat;
      out_imm       <= imm_ext;
      out_rs        <= rs;
      out_rt        <= rt;
      out_rd        <= rd;
      out_shamt     <= shamt;
      execute_bus   <= ex_c;
      memory_bus    <= mem_c;
      writeBack_bus <= wb_c;
    end
  end

endmodule
